// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/acknowledge, decode-side
// issue handshake and the branch redirect from execute.
// master = fetch unit, slave = memory/decode/execute side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [15:0] pc_out;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, halted,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, halted,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the 16-bit CPU. Owns the PC, keeps at most one
// instruction-memory request outstanding and holds each fetched word, its
// opcode and its PC until decode accepts it. A branch redirect squashes the
// held word or the in-flight request (the request itself is never withdrawn).
// Optional feature macro: FETCH_HALT_EN -- stop fetching once an instruction
// with opcode 4'hE has been accepted by decode; only reset leaves HALT.
//
// state   | meaning
// S_IDLE  | one cycle after reset, no request yet
// S_FETCH | request outstanding at imem_addr
// S_ISSUE | instruction held for decode (instr_valid=1)
// S_HALT  | fetch stopped, halted=1 (FETCH_HALT_EN builds only)
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0002
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_fetch_unit_if.master fetch_if
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        squash_q, squash_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        new_req;
`ifdef FETCH_HALT_EN
  logic        halted_q, halted_d;
`endif

  // Next-state decode; every output is taken from a register below.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opcode_d = opcode_q;
    pc_out_d = pc_out_q;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    new_req  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fetch_if.branch_taken) pc_d = fetch_if.branch_target;
        state_d = S_FETCH;
        new_req = 1'b1;
      end

      S_FETCH: begin
        if (fetch_if.imem_ack) begin
          squash_d = 1'b0;
          if (fetch_if.branch_taken) begin
            // data of this ack belongs to the old path: drop it, refetch
            pc_d    = fetch_if.branch_target;
            new_req = 1'b1;
          end else if (squash_q) begin
            // pc_q already holds the redirect target
            new_req = 1'b1;
          end else begin
            instr_d  = fetch_if.imem_rdata;
            opcode_d = fetch_if.imem_rdata[15:12];
            pc_out_d = addr_q;
            pc_d     = pc_q + PC_STEP;
            valid_d  = 1'b1;
            state_d  = S_ISSUE;
          end
        end else if (fetch_if.branch_taken) begin
          // request stays up at the old address until its ack arrives
          pc_d     = fetch_if.branch_target;
          squash_d = 1'b1;
        end
      end

      S_ISSUE: begin
        if (fetch_if.branch_taken) begin
          valid_d = 1'b0;
          pc_d    = fetch_if.branch_target;
          state_d = S_FETCH;
          new_req = 1'b1;
        end else if (fetch_if.instr_ready) begin
          valid_d = 1'b0;
`ifdef FETCH_HALT_EN
          if (opcode_q == 4'hE) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            new_req = 1'b1;
          end
`else
          state_d = S_FETCH;
          new_req = 1'b1;
`endif
        end
      end

`ifdef FETCH_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // the address only moves when a fresh request starts, so it is stable
    // for the whole life of a request
    if (new_req) addr_d = pc_d;
    req_d = (state_d == S_FETCH);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 16'h0000;
      opcode_q <= 4'h0;
      pc_out_q <= 16'h0000;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      pc_out_q <= pc_out_d;
`ifdef FETCH_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign fetch_if.imem_req    = req_q;
  assign fetch_if.imem_addr   = addr_q;
  assign fetch_if.instr_valid = valid_q;
  assign fetch_if.instr       = instr_q;
  assign fetch_if.opcode      = opcode_q;
  assign fetch_if.pc_out      = pc_out_q;
`ifdef FETCH_HALT_EN
  assign fetch_if.halted      = halted_q;
`else
  assign fetch_if.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model (expected next PC, memory contents).
module tb_instr_fetch_unit;
  localparam logic [15:0] PC_STEP = 16'h0002;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   dly_min;
  int   dly_max;
  logic [15:0] mem_ovr [int];

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .fetch_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: distinct word per address, never opcode E unless overridden.
  function automatic logic [15:0] memfn(input logic [15:0] a);
    logic [15:0] d;
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    d = {a[7:0] ^ 8'hA5, a[15:8] ^ a[7:0]};
    if (d[15:12] == 4'hE) d[15:12] = 4'h7;
    return d;
  endfunction

  // Memory responder: acts 2 time units after each rising edge.
  initial begin
    int m_cnt;
    int m_dly;
    logic m_req_prev;
    m_cnt = 0; m_dly = 0; m_req_prev = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bus.imem_ack = 1'b0;
        m_cnt = 0;
        m_req_prev = 1'b0;
      end else begin
        if (bus.imem_req && (!m_req_prev || bus.imem_ack)) begin
          m_cnt = 0;
          m_dly = $urandom_range(dly_max, dly_min);
        end
        if (bus.imem_req && m_cnt >= m_dly) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = memfn(bus.imem_addr);
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = 16'($urandom);
          if (bus.imem_req) m_cnt++;
        end
        m_req_prev = bus.imem_req;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.branch_taken = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 16'h0000;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0000 || bus.instr_valid !== 1'b0 ||
        bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b addr=%h valid=%b halted=%b want 0 0000 0 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.halted);
    end
    checks++;
    if (bus.instr !== 16'h0000 || bus.opcode !== 4'h0 || bus.pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: instr=%h opcode=%h pc_out=%h want 0000 0 0000",
               bus.instr, bus.opcode, bus.pc_out);
    end
    rst = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: req=%b want 0", bus.imem_req);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h want 1 0000", bus.imem_req, bus.imem_addr);
    end
    // reset while a slow request is outstanding abandons it
    dly_min = 8; dly_max = 8;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midreq: req=%b valid=%b want 0 0", bus.imem_req, bus.instr_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [15:0] req_addrs[$];
    logic [15:0] acc_pc[$];
    logic [15:0] acc_ins[$];
    logic [3:0]  acc_op[$];
    int          acc_cyc[$];
    mem_ovr.delete();
    mem_ovr[0] = 16'h1234;
    mem_ovr[2] = 16'h9005;
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step();
      if (bus.imem_req) req_addrs.push_back(bus.imem_addr);
      if (bus.instr_valid && bus.instr_ready) begin
        acc_pc.push_back(bus.pc_out);
        acc_ins.push_back(bus.instr);
        acc_op.push_back(bus.opcode);
        acc_cyc.push_back(c);
      end
    end
    checks++;
    if (req_addrs.size() != 2 || acc_pc.size() != 2) begin
      errors++;
      $display("FAIL zw_count: requests=%0d issues=%0d want 2 2", req_addrs.size(), acc_pc.size());
    end else begin
      checks++;
      if (req_addrs[0] !== 16'h0000 || req_addrs[1] !== 16'h0002) begin
        errors++;
        $display("FAIL zw_addr: %h %h want 0000 0002", req_addrs[0], req_addrs[1]);
      end
      checks++;
      if (acc_pc[0] !== 16'h0000 || acc_pc[1] !== 16'h0002) begin
        errors++;
        $display("FAIL zw_pc_out: %h %h want 0000 0002", acc_pc[0], acc_pc[1]);
      end
      checks++;
      if (acc_ins[0] !== 16'h1234 || acc_ins[1] !== 16'h9005 ||
          acc_op[0] !== 4'h1 || acc_op[1] !== 4'h9) begin
        errors++;
        $display("FAIL zw_instr: %h/%h %h/%h want 1234/1 9005/9",
                 acc_ins[0], acc_op[0], acc_ins[1], acc_op[1]);
      end
      checks++;
      if (acc_cyc[0] != 2 || acc_cyc[1] - acc_cyc[0] != 2) begin
        errors++;
        $display("FAIL zw_timing: first issue cycle %0d gap %0d want 2 2",
                 acc_cyc[0], acc_cyc[1] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [15:0] h_instr;
    logic [15:0] h_pc;
    logic [3:0]  h_op;
    int bad;
    mem_ovr.delete();
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(20, ok);
    checks++;
    if (!ok || bus.pc_out !== 16'h0000 || bus.instr !== memfn(16'h0000)) begin
      errors++;
      $display("FAIL stall_first: ok=%b pc_out=%h instr=%h want 1 0000 %h",
               ok, bus.pc_out, bus.instr, memfn(16'h0000));
    end
    h_instr = bus.instr; h_pc = bus.pc_out; h_op = bus.opcode;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.instr_valid !== 1'b1 || bus.instr !== h_instr || bus.pc_out !== h_pc ||
          bus.opcode !== h_op || bus.imem_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles want 0", bad);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h want 0 1 0002",
               bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch_squash();
    bit ok;
    mem_ovr.delete();
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(20, ok);
    dly_min = 3; dly_max = 3;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0004;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL sq_req4: req=%b addr=%h want 1 0004", bus.imem_req, bus.imem_addr);
    end
    step();
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0040;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL sq_hold_a: req=%b addr=%h want 1 0004", bus.imem_req, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL sq_hold_b: req=%b addr=%h want 1 0004", bus.imem_req, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL sq_redirect: req=%b addr=%h valid=%b want 1 0040 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b1;
    wait_valid(20, ok);
    checks++;
    if (!ok || bus.pc_out !== 16'h0040 || bus.instr !== memfn(16'h0040)) begin
      errors++;
      $display("FAIL sq_issue: ok=%b pc_out=%h instr=%h want 1 0040 %h",
               ok, bus.pc_out, bus.instr, memfn(16'h0040));
    end
  endtask

  task automatic test_branch_issue();
    bit ok;
    mem_ovr.delete();
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(20, ok);
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'h0100;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL br_issue: valid=%b req=%b addr=%h want 0 1 0100",
               bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || bus.pc_out !== 16'h0100) begin
      errors++;
      $display("FAIL br_issue_pc: ok=%b pc_out=%h want 1 0100", ok, bus.pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] acc_pc[$];
    mem_ovr.delete();
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b1;
    do_reset();
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'hFFFE;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_first: req=%b addr=%h want 1 fffe", bus.imem_req, bus.imem_addr);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.instr_valid && bus.instr_ready) acc_pc.push_back(bus.pc_out);
    end
    checks++;
    if (acc_pc.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: %0d issues want 2", acc_pc.size());
    end else begin
      checks++;
      if (acc_pc[0] !== 16'hFFFE || acc_pc[1] !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_pc: %h %h want fffe 0000", acc_pc[0], acc_pc[1]);
      end
    end
  endtask

  task automatic test_halt_op();
    bit ok;
    mem_ovr.delete();
    mem_ovr[2] = 16'hE000;
    dly_min = 0; dly_max = 0;
    bus.instr_ready = 1'b0;
    do_reset();
    wait_valid(20, ok);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    wait_valid(20, ok);
    checks++;
    if (!ok || bus.pc_out !== 16'h0002 || bus.opcode !== 4'hE) begin
      errors++;
      $display("FAIL halt_issue: ok=%b pc_out=%h opcode=%h want 1 0002 e", ok, bus.pc_out, bus.opcode);
    end
`ifdef FETCH_HALT_EN
    begin
      bit found;
      int bad;
      bus.branch_taken = 1'b1;
      bus.branch_target = 16'h0080;
      step();
      bus.branch_taken = 1'b0;
      checks++;
      if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0080) begin
        errors++;
        $display("FAIL halt_cancel: halted=%b req=%b addr=%h want 0 1 0080",
                 bus.halted, bus.imem_req, bus.imem_addr);
      end
      bus.instr_ready = 1'b1;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (bus.instr_valid && bus.pc_out == 16'h0002) begin
          found = 1'b1;
          break;
        end
      end
      step();
      checks++;
      if (!found || bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL halt_enter: found=%b halted=%b valid=%b req=%b want 1 1 0 0",
                 found, bus.halted, bus.instr_valid, bus.imem_req);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        bus.branch_taken = (i == 5);
        bus.branch_target = 16'h0200;
        step();
        if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) bad++;
      end
      bus.branch_taken = 1'b0;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL halt_stay: %0d cycles left halt want 0", bad);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus.halted !== 1'b0) begin
        errors++;
        $display("FAIL halt_reset: halted=%b want 0", bus.halted);
      end
    end
`else
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL op_e_plain: halted=%b req=%b addr=%h want 0 1 0004",
               bus.halted, bus.imem_req, bus.imem_addr);
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] next_exp;
    logic        p_req, p_ack, p_valid, p_ready, p_branch;
    logic [15:0] p_addr, p_instr, p_pcout;
    int          accepts;
    int          nfail;
    mem_ovr.delete();
    dly_min = 0; dly_max = 3;
    bus.instr_ready = 1'b0;
    do_reset();
    next_exp = 16'h0000;
    accepts = 0;
    nfail = 0;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_branch = 1'b0;
    p_addr = 16'h0000; p_instr = 16'h0000; p_pcout = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      if (p_req && !p_ack) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== p_addr) begin
          errors++; nfail++;
          if (nfail < 10) $display("FAIL rnd_req_hold c=%0d: req=%b addr=%h want 1 %h",
                                   c, bus.imem_req, bus.imem_addr, p_addr);
        end
      end
      if (bus.imem_req && (!p_req || p_ack)) begin
        checks++;
        if (bus.imem_addr !== next_exp) begin
          errors++; nfail++;
          if (nfail < 10) $display("FAIL rnd_req_addr c=%0d: addr=%h want %h",
                                   c, bus.imem_addr, next_exp);
        end
      end
      if (p_valid && !p_ready && !p_branch) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== p_instr || bus.pc_out !== p_pcout) begin
          errors++; nfail++;
          if (nfail < 10) $display("FAIL rnd_hold c=%0d: valid=%b instr=%h pc=%h want 1 %h %h",
                                   c, bus.instr_valid, bus.instr, bus.pc_out, p_instr, p_pcout);
        end
      end
      if (bus.instr_valid && !p_valid) begin
        checks++;
        if (!p_ack || bus.pc_out !== next_exp || bus.instr !== memfn(next_exp) ||
            bus.opcode !== bus.instr[15:12]) begin
          errors++; nfail++;
          if (nfail < 10) $display("FAIL rnd_issue c=%0d: ack=%b pc=%h instr=%h op=%h want 1 %h %h %h",
                                   c, p_ack, bus.pc_out, bus.instr, bus.opcode,
                                   next_exp, memfn(next_exp), memfn(next_exp) >> 12);
        end
      end
      bus.instr_ready   = ($urandom_range(9, 0) < 7);
      bus.branch_taken  = ($urandom_range(19, 0) == 0);
      bus.branch_target = 16'($urandom) & 16'hFFFE;
      if (bus.branch_taken) next_exp = bus.branch_target;
      else if (bus.instr_valid && bus.instr_ready) begin
        next_exp = bus.pc_out + PC_STEP;
        accepts++;
      end
      p_req = bus.imem_req; p_ack = bus.imem_ack; p_addr = bus.imem_addr;
      p_valid = bus.instr_valid; p_ready = bus.instr_ready; p_branch = bus.branch_taken;
      p_instr = bus.instr; p_pcout = bus.pc_out;
      step();
    end
    bus.branch_taken = 1'b0;
    checks++;
    if (accepts < 100) begin
      errors++;
      $display("FAIL rnd_progress: %0d issues accepted want >= 100", accepts);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dly_min = 0;
    dly_max = 0;
    bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 16'h0000;
    test_reset();
    test_zero_wait();
    test_stall();
    test_branch_squash();
    test_branch_issue();
    test_wrap();
    test_halt_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
